// File: rtl/axi_rresp_arbiter_s2m.sv
// R-channel return arbiter: 3 slave ports onto one master port.
// Optional RRESP_ERR_CNT_EN adds an error-beat counter (err_cnt/err_clr).
module axi_rresp_arbiter_s2m #(
  parameter int DW  = 32,
  parameter int IDW = 4,
  parameter int NUM = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arbiter_type,
  input  logic [NUM-1:0]     s_rvalid,
  input  logic [NUM*DW-1:0]  s_rdata,
  input  logic [NUM*IDW-1:0] s_rid,
  input  logic [2*NUM-1:0]   s_rresp,
  input  logic [NUM-1:0]     s_rlast,
  output logic [NUM-1:0]     s_rready,
  output logic               m_rvalid,
  output logic [DW-1:0]      m_rdata,
  output logic [IDW-1:0]     m_rid,
  output logic [1:0]         m_rresp,
  output logic               m_rlast,
  input  logic               m_rready,
  output logic               busy
`ifdef RRESP_ERR_CNT_EN
  ,
  input  logic               err_clr,
  output logic [7:0]         err_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [NUM-1:0] grant_q, grant_d;
  logic [NUM-1:0] last_q, last_d;
  logic [NUM-1:0] rr_win, fp_win;
  logic           burst_end;

  // Winner candidates for both modes
  always_comb begin
    fp_win = '0;
    if (s_rvalid[0])      fp_win = 3'b001;
    else if (s_rvalid[1]) fp_win = 3'b010;
    else if (s_rvalid[2]) fp_win = 3'b100;
    rr_win = '0;
    unique case (1'b1)
      last_q[0]: begin
        if (s_rvalid[1])      rr_win = 3'b010;
        else if (s_rvalid[2]) rr_win = 3'b100;
        else if (s_rvalid[0]) rr_win = 3'b001;
      end
      last_q[1]: begin
        if (s_rvalid[2])      rr_win = 3'b100;
        else if (s_rvalid[0]) rr_win = 3'b001;
        else if (s_rvalid[1]) rr_win = 3'b010;
      end
      default: begin
        if (s_rvalid[0])      rr_win = 3'b001;
        else if (s_rvalid[1]) rr_win = 3'b010;
        else if (s_rvalid[2]) rr_win = 3'b100;
      end
    endcase
  end

  // Pass-through mux from the granted slave
  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rid    = '0;
    m_rresp  = '0;
    m_rlast  = 1'b0;
    s_rready = '0;
    if (state_q == LOCKED) begin
      unique case (1'b1)
        grant_q[0]: begin
          m_rvalid    = s_rvalid[0];
          m_rdata     = s_rdata[0*DW +: DW];
          m_rid       = s_rid[0*IDW +: IDW];
          m_rresp     = s_rresp[0 +: 2];
          m_rlast     = s_rlast[0];
          s_rready[0] = m_rready;
        end
        grant_q[1]: begin
          m_rvalid    = s_rvalid[1];
          m_rdata     = s_rdata[1*DW +: DW];
          m_rid       = s_rid[1*IDW +: IDW];
          m_rresp     = s_rresp[2 +: 2];
          m_rlast     = s_rlast[1];
          s_rready[1] = m_rready;
        end
        grant_q[2]: begin
          m_rvalid    = s_rvalid[2];
          m_rdata     = s_rdata[2*DW +: DW];
          m_rid       = s_rid[2*IDW +: IDW];
          m_rresp     = s_rresp[4 +: 2];
          m_rlast     = s_rlast[2];
          s_rready[2] = m_rready;
        end
        default: ;
      endcase
    end
  end

  assign burst_end = m_rvalid & m_rready & m_rlast;
  assign busy      = (state_q == LOCKED);

  // Next-state: grant in IDLE, release after the RLAST handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|s_rvalid) begin
          grant_d = arbiter_type ? fp_win : rr_win;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (burst_end) begin
          state_d = IDLE;
          last_d  = grant_q;
          grant_d = '0;
        end
      end
    endcase
  end

  // State, grant and round-robin history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef RRESP_ERR_CNT_EN
  logic err_beat;
  assign err_beat = m_rvalid & m_rready & m_rresp[1];

  // Saturating count of SLVERR/DECERR beats; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_cnt <= '0;
    else if (err_clr)                    err_cnt <= '0;
    else if (err_beat && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_axi_rresp_arbiter_s2m.sv
// Scoreboard bench for axi_rresp_arbiter_s2m.
// Slave queues feed the DUT; expected master beats are checked in grant order.
module tb_axi_rresp_arbiter_s2m;
  localparam int DW  = 32;
  localparam int IDW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arbiter_type;
  logic [2:0]    s_rvalid;
  logic [3*DW-1:0]  s_rdata;
  logic [3*IDW-1:0] s_rid;
  logic [5:0]    s_rresp;
  logic [2:0]    s_rlast;
  logic [2:0]    s_rready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [IDW-1:0] m_rid;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rready;
  logic          busy;
`ifdef RRESP_ERR_CNT_EN
  logic          err_clr;
  logic [7:0]    err_cnt;
`endif

  always #5 clk = ~clk;

  axi_rresp_arbiter_s2m #(.DW(DW), .IDW(IDW), .NUM(3)) dut (
    .clk(clk), .rst_n(rst_n), .arbiter_type(arbiter_type),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .busy(busy)
`ifdef RRESP_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]  sl;
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      sq[3][$];
  beat_t      exp_q[$];
  logic [2:0] en;
  int checks = 0;
  int errors = 0;
  int cyc;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_burst(input int sl, input int n, input logic [1:0] resp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.sl   = 2'(sl);
      b.data = $urandom;
      b.id   = 4'($urandom);
      b.resp = resp;
      b.last = (k == n - 1);
      sq[sl].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive(input logic rdy);
    m_rready = rdy;
    for (int i = 0; i < 3; i++) begin
      if (en[i] && sq[i].size() > 0) begin
        s_rvalid[i]           = 1'b1;
        s_rdata[i*DW +: DW]   = sq[i][0].data;
        s_rid[i*IDW +: IDW]   = sq[i][0].id;
        s_rresp[i*2 +: 2]     = sq[i][0].resp;
        s_rlast[i]            = sq[i][0].last;
      end else begin
        s_rvalid[i]           = 1'b0;
        s_rdata[i*DW +: DW]   = '0;
        s_rid[i*IDW +: IDW]   = '0;
        s_rresp[i*2 +: 2]     = '0;
        s_rlast[i]            = 1'b0;
      end
    end
  endtask

  task automatic observe();
    beat_t e;
    if (m_rvalid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q[0];
        check("s_rready", 64'(s_rready),
              m_rready ? (64'd1 << e.sl) : 64'd0);
        check("busy", 64'(busy), 64'd1);
        if (m_rready) begin
          void'(exp_q.pop_front());
          check("rdata", 64'(m_rdata), 64'(e.data));
          check("rid",   64'(m_rid),   64'(e.id));
          check("rresp", 64'(m_rresp), 64'(e.resp));
          check("rlast", 64'(m_rlast), 64'(e.last));
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (s_rvalid[i] && s_rready[i]) void'(sq[i].pop_front());
  endtask

  task automatic run(input int max, input logic toggle,
                     input logic [2:0] late_mask, input int late_cyc,
                     output int n);
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      if (n == late_cyc) en = en | late_mask;
      @(negedge clk);
      drive(toggle ? ~n[0] : 1'b1);
      #1;
      observe();
      n++;
    end
  endtask

  task automatic idle(input int n, input logic chk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(1'b1);
      #1;
      if (chk) begin
        check("idle_rvalid", 64'(m_rvalid), 64'd0);
        check("idle_rready", 64'(s_rready), 64'd0);
        check("idle_busy",   64'(busy),     64'd0);
      end
      observe();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    arbiter_type = 1'b0;
    en           = 3'b111;
    m_rready     = 1'b1;
    s_rvalid     = 3'b111;
    s_rdata      = '0;
    s_rid        = '0;
    s_rresp      = '0;
    s_rlast      = 3'b111;
`ifdef RRESP_ERR_CNT_EN
    err_clr      = 1'b0;
`endif
    #23;
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_rready", 64'(s_rready), 64'd0);
    check("rst_busy",   64'(busy),     64'd0);
    @(negedge clk);
    drive(1'b1);
    rst_n = 1'b1;

    // Reset release, no traffic
    idle(10, 1'b1);

    // Round robin, all slaves requesting: 0,1,2,0
    load_burst(0, 2, 2'b00);
    load_burst(1, 2, 2'b01);
    load_burst(2, 2, 2'b00);
    load_burst(0, 2, 2'b00);
    run(60, 1'b0, 3'b000, -1, cyc);
    check("t2_done", 64'(exp_q.size()), 64'd0);
    check("t2_cycles", 64'(cyc), 64'd12);
    idle(2, 1'b1);

    // Fixed priority: slave1 first, then slave0 despite last_winner=010
    arbiter_type = 1'b1;
    en = 3'b110;
    load_burst(1, 2, 2'b00);
    load_burst(0, 2, 2'b11);
    load_burst(2, 1, 2'b00);
    run(60, 1'b0, 3'b001, 1, cyc);
    check("t3_done", 64'(exp_q.size()), 64'd0);
    idle(2, 1'b1);

    // Backpressure on a 4-beat slave2 burst, slave0 arriving mid-burst
    arbiter_type = 1'b0;
    en = 3'b100;
    load_burst(2, 4, 2'b00);
    load_burst(0, 2, 2'b00);
    run(60, 1'b1, 3'b001, 3, cyc);
    check("t4_done", 64'(exp_q.size()), 64'd0);
    check("t4_cycles", 64'(cyc), 64'd13);
    idle(2, 1'b1);

    // Reset on beat 2 of a 4-beat burst
    en = 3'b111;
    load_burst(1, 4, 2'b00);
    run(3, 1'b0, 3'b000, -1, cyc);
    rst_n = 1'b0;
    #1;
    check("t5_rvalid", 64'(m_rvalid), 64'd0);
    check("t5_rready", 64'(s_rready), 64'd0);
    check("t5_busy",   64'(busy),     64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) sq[i].delete();
    @(negedge clk);
    drive(1'b1);
    rst_n = 1'b1;
    idle(2, 1'b1);
    load_burst(0, 1, 2'b00);
    load_burst(1, 1, 2'b00);
    run(30, 1'b0, 3'b000, -1, cyc);
    check("t5_done", 64'(exp_q.size()), 64'd0);
    check("t5_cycles", 64'(cyc), 64'd4);
    idle(2, 1'b1);

`ifdef RRESP_ERR_CNT_EN
    // Error counter saturation and clear
    load_burst(0, 300, 2'b10);
    run(400, 1'b0, 3'b000, -1, cyc);
    check("t6_done", 64'(exp_q.size()), 64'd0);
    idle(1, 1'b0);
    check("err_sat", 64'(err_cnt), 64'hFF);
    @(negedge clk);
    err_clr = 1'b1;
    drive(1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("err_clr", 64'(err_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
